// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and helpers for the branch target buffer.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package branch_predict_ctrl_pkg;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  localparam logic [1:0] CTR_SN = 2'b00;
  localparam logic [1:0] CTR_WN = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  // The tag field is sized for the widest legal tag (PC bits above the word
  // offset). Narrower tags are zero-extended, so the record type does not
  // depend on the module parameters.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } entry_t;

  // Word index into the table: PC[idx_w+1:2], returned zero-extended.
  function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Tag: PC[idx_w+2 +: tag_w], returned zero-extended.
  function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc, input int idx_w,
                                                  input int tag_w);
    logic [31:0] mask;
    logic [31:0] sh;
    mask = (32'd1 << tag_w) - 32'd1;
    sh   = (pc >> (idx_w + 2)) & mask;
    return TAG_MAX_W'(sh);
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch-lookup, EX-resolution and statistics signals of the branch predictor.
// Latency: n/a (wiring only).
// Backpressure: none; EX resolution is held off by StallE.
interface branch_predict_ctrl_if;
  // IF-stage lookup
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  // EX-stage resolution
  logic        BrValidE;
  logic        StallE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BranchTarget;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        error_flush;
  logic [31:0] RecoverPC;
  // Performance statistics
  logic [31:0] BrCount;
  logic [31:0] MissCount;

  // Predictor side
  modport slave (
    input  PCF, BrValidE, StallE, PCE, BranchE, BranchTarget, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, error_flush, RecoverPC, BrCount, MissCount
  );

  // Pipeline side
  modport master (
    output PCF, BrValidE, StallE, PCE, BranchE, BranchTarget, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, error_flush, RecoverPC, BrCount, MissCount
  );
endinterface

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// 2-bit saturating counter next-state function (SN<->WN<->WT<->ST).
// Latency: combinational.
// Backpressure: none.
module sat_counter2
  import branch_predict_ctrl_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Step toward ST on taken, toward SN on not taken, holding at the ends.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SN) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX resolve/flush, stats.
// Latency: lookup and flush are combinational; table/stat updates land on the next edge.
// Backpressure: StallE defers resolution; a stalled branch resolves once when it drops.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic                 CPU_CLK,
  input  logic                 CPU_RST,
  branch_predict_ctrl_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_W;

  entry_t table_q [ENTRIES];
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  logic [IDX_W-1:0]     f_idx, e_idx;
  logic [TAG_MAX_W-1:0] f_tag, e_tag;
  entry_t               f_ent, e_ent, entry_d;
  logic                 f_hit, e_hit;
  logic                 upd, mispredict, wr_en;
  logic [1:0]           ctr_nxt;
  logic [31:0]          pce_plus4;

  assign f_idx = IDX_W'(idx_of(bp.PCF, IDX_W));
  assign f_tag = tag_of(bp.PCF, IDX_W, TAG_W);
  assign e_idx = IDX_W'(idx_of(bp.PCE, IDX_W));
  assign e_tag = tag_of(bp.PCE, IDX_W, TAG_W);

  assign f_ent = table_q[f_idx];
  assign e_ent = table_q[e_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
  assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign bp.PredTakenF  = f_hit && f_ent.ctr[1];
  assign bp.PredTargetF = f_hit ? f_ent.target : 32'd0;

  // Resolution is suppressed while reset is held so no flush escapes during reset.
  assign upd        = bp.BrValidE && !bp.StallE && !CPU_RST;
  assign mispredict = upd && ((bp.BranchE != bp.PredTakenE) ||
                              (bp.BranchE && bp.PredTakenE &&
                               (bp.PredTargetE != bp.BranchTarget)));
  assign pce_plus4  = bp.PCE + 32'd4;

  assign bp.error_flush = mispredict;
  assign bp.RecoverPC   = (mispredict && bp.BranchE) ? bp.BranchTarget : pce_plus4;
  assign bp.BrCount     = br_count_q;
  assign bp.MissCount   = miss_count_q;

  sat_counter2 u_sat_counter2 (
    .ctr_i   (e_ent.ctr),
    .taken_i (bp.BranchE),
    .ctr_o   (ctr_nxt)
  );

  // Build the new contents of the EX-indexed entry; not-taken misses leave it alone.
  always_comb begin
    entry_d = e_ent;
    wr_en   = 1'b0;
    if (upd) begin
      if (e_hit) begin
        wr_en       = 1'b1;
        entry_d.ctr = ctr_nxt;
        if (bp.BranchE) entry_d.target = bp.BranchTarget;
      end else if (bp.BranchE) begin
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = e_tag;
        entry_d.target = bp.BranchTarget;
        entry_d.ctr    = CTR_WT;
      end
    end
  end

  // Statistics next state, wrapping naturally at 2^32.
  always_comb begin
    br_count_d   = br_count_q + (upd ? 32'd1 : 32'd0);
    miss_count_d = miss_count_q + (mispredict ? 32'd1 : 32'd0);
  end

  // Table and counter registers; reset clears every entry to invalid/WN.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: CTR_WN};
      end
      br_count_q   <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      if (wr_en) table_q[e_idx] <= entry_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench: directed vector table, stall/reset sequences, random vs model.
module tb_branch_predict_ctrl;

  logic CPU_CLK = 1'b0;
  logic CPU_RST = 1'b1;
  always #5 CPU_CLK = ~CPU_CLK;

  branch_predict_ctrl_if bif ();

  branch_predict_ctrl #(.IDX_W(6), .TAG_W(24)) dut (
    .CPU_CLK (CPU_CLK),
    .CPU_RST (CPU_RST),
    .bp      (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pcf, input logic vld, input logic stall,
                       input logic [31:0] pce, input logic br, input logic [31:0] bt,
                       input logic pte, input logic [31:0] ptge);
    bif.PCF          = pcf;
    bif.BrValidE     = vld;
    bif.StallE       = stall;
    bif.PCE          = pce;
    bif.BranchE      = br;
    bif.BranchTarget = bt;
    bif.PredTakenE   = pte;
    bif.PredTargetE  = ptge;
  endtask

  // ---------------- behavioural reference model ----------------
  // Strength 0..3 stands for how strongly a branch is believed taken.
  bit          m_valid [64];
  longint      m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_str   [64];
  longint      m_br;
  longint      m_miss;

  function automatic int m_index(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % 64);
  endfunction

  function automatic longint m_tagof(input logic [31:0] pc);
    return (longint'(pc) / 256) % (longint'(1) << 24);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'd0;
      m_str[i]   = 1;
    end
    m_br   = 0;
    m_miss = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
    int i;
    i = m_index(pc);
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      taken = (m_str[i] >= 2);
      tgt   = m_tgt[i];
    end else begin
      taken = 1'b0;
      tgt   = 32'd0;
    end
  endtask

  task automatic m_resolve(input logic [31:0] pce, input logic br, input logic [31:0] bt);
    int i;
    i = m_index(pce);
    if (m_valid[i] && m_tag[i] == m_tagof(pce)) begin
      m_str[i] = br ? ((m_str[i] < 3) ? m_str[i] + 1 : 3) : ((m_str[i] > 0) ? m_str[i] - 1 : 0);
      if (br) m_tgt[i] = bt;
    end else if (br) begin
      m_valid[i] = 1;
      m_tag[i]   = m_tagof(pce);
      m_tgt[i]   = bt;
      m_str[i]   = 2;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] pcf;
    logic        vld;
    logic [31:0] pce;
    logic        br;
    logic [31:0] bt;
    logic        pte;
    logic [31:0] ptge;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_fl;
    logic [31:0] e_rpc;
    logic [31:0] e_br;
    logic [31:0] e_miss;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] pool_pc  [7];
  logic [31:0] pool_tgt [4];

  initial begin
    logic        ept;
    logic [31:0] eptg;
    logic        pte;
    logic [31:0] ptge;
    logic        mis;
    logic [31:0] erpc;
    logic [31:0] pcf, pce, bt;
    logic        vld, stall, br;

    // pcf, vld, pce, br, bt, pte, ptge | pt, ptg, flush, recover, BrCount, MissCount
    vecs[0]  = '{32'h40,  1'b0, 32'h40, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h44, 32'd0, 32'd0};
    vecs[1]  = '{32'h40,  1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h10, 32'd0, 32'd0};
    vecs[2]  = '{32'h40,  1'b0, 32'h40, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h10, 1'b0, 32'h44, 32'd1, 32'd1};
    vecs[3]  = '{32'h40,  1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 32'h44, 32'd1, 32'd1};
    vecs[4]  = '{32'h40,  1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 32'h44, 32'd2, 32'd1};
    vecs[5]  = '{32'h40,  1'b1, 32'h40, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h44, 32'd3, 32'd1};
    vecs[6]  = '{32'h40,  1'b0, 32'h40, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h10, 1'b0, 32'h44, 32'd4, 32'd2};
    vecs[7]  = '{32'h140, 1'b0, 32'h40, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h44, 32'd4, 32'd2};
    vecs[8]  = '{32'h40,  1'b1, 32'h40, 1'b1, 32'h20, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h20, 32'd4, 32'd2};
    vecs[9]  = '{32'h40,  1'b0, 32'h40, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h20, 1'b0, 32'h44, 32'd5, 32'd3};
    vecs[10] = '{32'h80,  1'b1, 32'h80, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h84, 32'd5, 32'd3};
    vecs[11] = '{32'h80,  1'b0, 32'h80, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h84, 32'd6, 32'd3};

    pool_pc  = '{32'h40, 32'h140, 32'h80, 32'h1080, 32'hFFFF_FFFC, 32'h0, 32'h100};
    pool_tgt = '{32'h10, 32'h20, 32'h300, 32'h8000_0000};

    // ---- reset state ----
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h10, 1'b0, 32'h0);
    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    #1;
    chk("rst_pred_taken", 32'(bif.PredTakenF), 32'd0);
    chk("rst_pred_target", bif.PredTargetF, 32'd0);
    chk("rst_flush", 32'(bif.error_flush), 32'd0);
    chk("rst_brcount", bif.BrCount, 32'd0);
    chk("rst_misscount", bif.MissCount, 32'd0);
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // ---- directed table ----
    for (int v = 0; v < 12; v++) begin
      @(negedge CPU_CLK);
      drive(vecs[v].pcf, vecs[v].vld, 1'b0, vecs[v].pce, vecs[v].br, vecs[v].bt,
            vecs[v].pte, vecs[v].ptge);
      #1;
      chk($sformatf("vec%0d_pred_taken", v), 32'(bif.PredTakenF), 32'(vecs[v].e_pt));
      chk($sformatf("vec%0d_pred_target", v), bif.PredTargetF, vecs[v].e_ptg);
      chk($sformatf("vec%0d_flush", v), 32'(bif.error_flush), 32'(vecs[v].e_fl));
      chk($sformatf("vec%0d_recover", v), bif.RecoverPC, vecs[v].e_rpc);
      chk($sformatf("vec%0d_brcount", v), bif.BrCount, vecs[v].e_br);
      chk($sformatf("vec%0d_misscount", v), bif.MissCount, vecs[v].e_miss);
    end

    // ---- stalled branch resolves exactly once when the stall drops ----
    for (int c = 0; c < 3; c++) begin
      @(negedge CPU_CLK);
      drive(32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
      #1;
      chk($sformatf("stall%0d_flush", c), 32'(bif.error_flush), 32'd0);
      chk($sformatf("stall%0d_brcount", c), bif.BrCount, 32'd6);
      chk($sformatf("stall%0d_pred_taken", c), 32'(bif.PredTakenF), 32'd0);
    end
    @(negedge CPU_CLK);
    drive(32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    chk("unstall_flush", 32'(bif.error_flush), 32'd1);
    chk("unstall_recover", bif.RecoverPC, 32'h300);
    @(negedge CPU_CLK);
    drive(32'h200, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("unstall_brcount", bif.BrCount, 32'd7);
    chk("unstall_misscount", bif.MissCount, 32'd4);
    chk("unstall_pred_taken", 32'(bif.PredTakenF), 32'd1);
    chk("unstall_pred_target", bif.PredTargetF, 32'h300);

    // ---- reset on the same edge as a taken update ----
    @(negedge CPU_CLK);
    drive(32'h40, 1'b1, 1'b0, 32'h404, 1'b1, 32'h500, 1'b0, 32'h0);
    CPU_RST = 1'b1;
    #1;
    chk("inrst_flush", 32'(bif.error_flush), 32'd0);
    chk("inrst_pred_taken", 32'(bif.PredTakenF), 32'd0);
    chk("inrst_pred_target", bif.PredTargetF, 32'd0);
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    drive(32'h404, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("postrst_pred_taken", 32'(bif.PredTakenF), 32'd0);
    chk("postrst_brcount", bif.BrCount, 32'd0);
    chk("postrst_misscount", bif.MissCount, 32'd0);
    @(negedge CPU_CLK);
    drive(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("postrst_old_entry", 32'(bif.PredTakenF), 32'd0);

    // ---- randomized traffic against the model ----
    m_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge CPU_CLK);
      pcf   = pool_pc[$urandom_range(0, 6)];
      pce   = pool_pc[$urandom_range(0, 6)];
      bt    = pool_tgt[$urandom_range(0, 3)];
      vld   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        m_lookup(pce, pte, ptge);
      end else begin
        pte  = 1'($urandom_range(0, 1));
        ptge = pool_tgt[$urandom_range(0, 3)];
      end
      drive(pcf, vld, stall, pce, br, bt, pte, ptge);
      m_lookup(pcf, ept, eptg);
      mis  = vld && !stall && ((br != pte) || (br && pte && ptge != bt));
      erpc = (mis && br) ? bt : pce + 32'd4;
      #1;
      chk($sformatf("rnd%0d_pred_taken", c), 32'(bif.PredTakenF), 32'(ept));
      chk($sformatf("rnd%0d_pred_target", c), bif.PredTargetF, eptg);
      chk($sformatf("rnd%0d_flush", c), 32'(bif.error_flush), 32'(mis));
      chk($sformatf("rnd%0d_recover", c), bif.RecoverPC, erpc);
      chk($sformatf("rnd%0d_brcount", c), bif.BrCount, 32'(m_br));
      chk($sformatf("rnd%0d_misscount", c), bif.MissCount, 32'(m_miss));
      if (vld && !stall) begin
        m_br++;
        if (mis) m_miss++;
        m_resolve(pce, br, bt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Direct-mapped branch target buffer with per-entry 2-bit saturating counters that steers the next-PC mux of the 5-stage RISC-V pipeline. It predicts conditional branches in IF and resolves them in EX. On a misprediction it raises `error_flush` and supplies the recovery PC. It also keeps branch and misprediction statistics for the performance report.

## Interface
Parameters:
- `IDX_W`, default 6: index width; table holds 2^IDX_W entries.
- `TAG_W`, default 24: tag width, taken from `PC[IDX_W+2 +: TAG_W]`.

Ports:
- `CPU_CLK`, in, 1: the single clock.
- `CPU_RST`, in, 1: asynchronous, active-high reset.
- `PCF`, in, 32: IF-stage PC used for lookup.
- `PredTakenF`, out, 1: predict taken for `PCF`.
- `PredTargetF`, out, 32: predicted target, valid when `PredTakenF`=1.
- `BrValidE`, in, 1: a conditional branch is in EX this cycle.
- `StallE`, in, 1: EX is stalled; no update, no flush.
- `PCE`, in, 32: PC of the EX-stage instruction.
- `BranchE`, in, 1: actual branch outcome (1 = taken).
- `BranchTarget`, in, 32: actual taken target.
- `PredTakenE`, in, 1: the `PredTakenF` value carried down the pipeline with the instruction.
- `PredTargetE`, in, 32: the `PredTargetF` value carried down likewise.
- `error_flush`, out, 1: misprediction; flush IF/ID and redirect fetch.
- `RecoverPC`, out, 32: correct next PC, valid while `error_flush`=1.
- `BrCount`, out, 32: resolved-branch counter.
- `MissCount`, out, 32: misprediction counter.

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[32]`, `ctr[2]`.
  - `ctr` encoding: 00 strongly-not-taken (SN), 01 weakly-not-taken (WN), 10 weakly-taken (WT), 11 strongly-taken (ST).
- Lookup (combinational from registered table):
  - `idx = PCF[IDX_W+1:2]`.
  - `hit = valid[idx] && tag[idx]==PCF tag`.
  - `PredTakenF = hit && ctr[idx][1]`.
  - `PredTargetF = target[idx]` on hit, else 0.
- Resolution is active when `upd = BrValidE && !StallE`.
  - `mispredict = upd && ((BranchE != PredTakenE) || (BranchE && PredTakenE && PredTargetE != BranchTarget))`.
  - `error_flush = mispredict`.
  - `RecoverPC = BranchE ? BranchTarget : PCE + 4`, modulo 2^32; when `error_flush`=0 it is driven as `PCE + 4`.
- Update, on the clock edge when `upd`, at the entry indexed by `PCE`:
  - Tag hit:
    - Counter transitions: SN→WN→WT→ST when taken, reverse when not taken, saturating at 00 and 11.
    - `target ← BranchTarget` when taken.
  - Tag miss or invalid, branch taken: allocate the entry (`valid←1`, tag, `target←BranchTarget`, `ctr←WT`).
  - Tag miss or invalid, branch not taken: no allocation, entry unchanged.
- Statistics:
  - `BrCount` increments on every `upd`.
  - `MissCount` increments on every `mispredict`.
  - Both wrap modulo 2^32.
- Priority outside this block: `error_flush` overrides `JalrE`, `JalD` and the prediction in the next-PC selection. This block does not see jal/jalr.

## Timing
- Lookup has zero latency; `PredTakenF`/`PredTargetF` are valid in the same cycle as `PCF`.
- `error_flush`/`RecoverPC` are combinational in the EX cycle. The fetch redirect takes effect on the next edge, so the mispredict penalty is 2 cycles.
- Table write is visible to lookups one cycle after the update edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (read-before-write, no bypass).
- `StallE`=1 with `BrValidE`=1 has no effect. The instruction resolves in the cycle `StallE` drops, exactly once.
- Reset:
  - All `valid`←0, all `ctr`←WN, `target` and `tag` ←0.
  - `BrCount`, `MissCount` ←0.
  - Outputs during reset: `PredTakenF`=0, `PredTargetF`=0, `error_flush`=0.
  - Reset asserted mid-operation cancels any pending update on that edge.

## Structure
- Shared package holds:
  - the counter encoding constants SN/WN/WT/ST;
  - the entry record typedef;
  - the `idx`/tag extraction helper functions.
- One sub-module: `sat_counter2`, the 2-bit saturating next-state function, instantiated once on the update path.
- Table arrays and statistics counters live in `branch_predict_ctrl`.

## Test plan
- After reset, lookup `PCF=0x0000_0040` → `PredTakenF=0`. Resolve it taken to `0x0000_0010` with `PredTakenE=0` → `error_flush=1`, `RecoverPC=0x10`, `MissCount=1`. Next-cycle lookup → `PredTakenF=1`, `PredTargetF=0x10`.
- Same branch resolved taken 3× then not-taken 1× → `ctr` goes WT,ST,ST,WT. Still predicts taken. Only the not-taken resolution flushes, with `RecoverPC=0x44`.
- Aliasing: `PCE=0x40` allocated, then `PCF=0x140` (same idx, different tag) → `PredTakenF=0`.
- Predicted taken, actual taken, `PredTargetE=0x10`, `BranchTarget=0x20` → `error_flush=1`, `RecoverPC=0x20`, entry target becomes `0x20`.
- `BrValidE=1`, `StallE=1` for 3 cycles, then `StallE=0` → no flush during the stall, one update, `BrCount` +1.
- Assert `CPU_RST` in the same cycle as a taken update → table stays invalid and counters read 0.
